pll_lock_supervisor: RTL and testbench

//   Sequences the board PLL (SB_PLL40_CORE wrapper) at power-up and on lock loss.

---
 rtl/pll_sup_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/pll_lock_supervisor.sv | 159 +++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      SETTLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } pllSupState_t;

   // One timer serves every state, so it must hold the largest terminal count.
   function automatic int timerWidth(input int rst_cycles, input int lock_timeout,
                                     input int settle_cycles);
      int m;
      m = rst_cycles;
      if (lock_timeout > m) m = lock_timeout;
      if (settle_cycles > m) m = settle_cycles;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer, async active-low reset, resets to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL power-up / lock-loss sequencer on the board reference clock.
// Build option LOCK_GLITCH_FILTER_EN: lock loss in RUN needs GLITCH_CYCLES consecutive low cycles.
//
// state     | meaning
// PLL_RST   | PLL held in reset for RST_CYCLES
// WAIT_LOCK | PLL released, waiting for synced lock (timeout -> retry or FAIL)
// SETTLE    | lock seen, must stay high SETTLE_CYCLES in a row
// RUN       | core reset released, watching for lock loss
// FAIL      | retries exhausted, sticky until resetN or relockReq
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 100000,
   parameter int SETTLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 3,
   parameter int GLITCH_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             isLocked,
   input  logic             relockReq,
   output logic             pllResetN,
   output logic             coreResetN,
   output logic             running,
   output logic             failed,
   output logic [CNT_W-1:0] lockLossCount
);

   localparam int TIMER_W = timerWidth(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
   localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
   localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
   localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);
   localparam logic [CNT_W-1:0]   CNT_SAT     = '1;

   pllSupState_t       state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [RETRY_W-1:0] retries_q, retries_d;
   logic [CNT_W-1:0]   loss_cnt_q, loss_cnt_d;
   logic               pll_rst_n_q, pll_rst_n_d;
   logic               core_rst_n_q, core_rst_n_d;
   logic               running_q, running_d;
   logic               failed_q, failed_d;
   logic               lock_s;
   logic               lock_lost;

   sync_2ff u_lock_sync (
      .clk   (clk),
      .rst_n (resetN),
      .d     (isLocked),
      .q     (lock_s)
   );

`ifdef LOCK_GLITCH_FILTER_EN
   localparam int GLITCH_W = $clog2(GLITCH_CYCLES + 1);
   localparam logic [GLITCH_W-1:0] GLITCH_LAST = GLITCH_W'(GLITCH_CYCLES - 1);

   logic [GLITCH_W-1:0] glitch_q, glitch_d;

   always_comb begin
      glitch_d = '0;
      if (state_q == RUN && !lock_s && glitch_q != GLITCH_LAST)
         glitch_d = glitch_q + GLITCH_W'(1);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) glitch_q <= '0;
      else         glitch_q <= glitch_d;
   end

   assign lock_lost = !lock_s && (glitch_q == GLITCH_LAST);
`else
   assign lock_lost = !lock_s;
`endif

   always_comb begin
      state_d    = state_q;
      retries_d  = retries_q;
      loss_cnt_d = loss_cnt_q;
      case (state_q)
         PLL_RST: begin
            if (timer_q == RST_LAST) state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d = SETTLE;
            end else if (timer_q == LOCK_LAST) begin
               if (retries_q == RETRY_MAX) begin
                  state_d = FAIL;
               end else begin
                  retries_d = retries_q + RETRY_W'(1);
                  state_d   = PLL_RST;
               end
            end
         end
         SETTLE: begin
            if (!lock_s)                    state_d = WAIT_LOCK;
            else if (timer_q == SETTLE_LAST) state_d = RUN;
         end
         RUN: begin
            retries_d = '0;
            if (lock_lost) begin
               state_d = PLL_RST;
               if (loss_cnt_q != CNT_SAT) loss_cnt_d = loss_cnt_q + CNT_W'(1);
            end
         end
         FAIL: ;
         default: state_d = PLL_RST;
      endcase

      // Relock wins over any other transition but leaves a same-cycle loss count intact.
      if (relockReq) begin
         state_d   = PLL_RST;
         retries_d = '0;
      end

      if (relockReq || state_d != state_q || state_q inside {RUN, FAIL})
         timer_d = '0;
      else
         timer_d = timer_q + TIMER_W'(1);

      pll_rst_n_d  = (state_d != PLL_RST);
      core_rst_n_d = (state_d == RUN);
      running_d    = (state_d == RUN);
      failed_d     = (state_d == FAIL);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q      <= PLL_RST;
         timer_q      <= '0;
         retries_q    <= '0;
         loss_cnt_q   <= '0;
         pll_rst_n_q  <= 1'b0;
         core_rst_n_q <= 1'b0;
         running_q    <= 1'b0;
         failed_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         retries_q    <= retries_d;
         loss_cnt_q   <= loss_cnt_d;
         pll_rst_n_q  <= pll_rst_n_d;
         core_rst_n_q <= core_rst_n_d;
         running_q    <= running_d;
         failed_q     <= failed_d;
      end
   end

   assign pllResetN     = pll_rst_n_q;
   assign coreResetN    = core_rst_n_q;
   assign running       = running_q;
   assign failed        = failed_q;
   assign lockLossCount = loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with a queue-based expected-value scoreboard.
module tb_pll_lock_supervisor;

   localparam int RST_CYCLES    = 4;
   localparam int LOCK_TIMEOUT  = 16;
   localparam int SETTLE_CYCLES = 8;
   localparam int MAX_RETRIES   = 2;
   localparam int GLITCH_CYCLES = 3;
   localparam int CNT_W         = 8;
`ifdef LOCK_GLITCH_FILTER_EN
   localparam int LOSS_LAT = 2 + GLITCH_CYCLES;
`else
   localparam int LOSS_LAT = 3;
`endif
   // lock edge -> coreResetN: 2 sync + 1 detect + full settle
   localparam int LOCK_TO_CORE = 3 + SETTLE_CYCLES;

   logic             clk;
   logic             resetN;
   logic             isLocked;
   logic             relockReq;
   logic             pllResetN;
   logic             coreResetN;
   logic             running;
   logic             failed;
   logic [CNT_W-1:0] lockLossCount;

   int          n_checks = 0;
   int          n_errors = 0;
   string       tag_q[$];
   int unsigned exp_q[$];

   pll_lock_supervisor #(
      .RST_CYCLES    (RST_CYCLES),
      .LOCK_TIMEOUT  (LOCK_TIMEOUT),
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .MAX_RETRIES   (MAX_RETRIES),
      .GLITCH_CYCLES (GLITCH_CYCLES),
      .CNT_W         (CNT_W)
   ) dut (
      .clk           (clk),
      .resetN        (resetN),
      .isLocked      (isLocked),
      .relockReq     (relockReq),
      .pllResetN     (pllResetN),
      .coreResetN    (coreResetN),
      .running       (running),
      .failed        (failed),
      .lockLossCount (lockLossCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic int unsigned snap();
      return {20'd0, lockLossCount, pllResetN, coreResetN, running, failed};
   endfunction

   function automatic int unsigned exp_snap(input int pll, input int core, input int run,
                                            input int fl, input int cnt);
      return cnt * 16 + pll * 8 + core * 4 + run * 2 + fl;
   endfunction

   function automatic logic sig(input int sel);
      case (sel)
         0:       return pllResetN;
         1:       return coreResetN;
         2:       return running;
         default: return failed;
      endcase
   endfunction

   task automatic sb_push(input string tag, input int unsigned v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic sb_check(input int unsigned obs);
      string       tag;
      int unsigned exp_v;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_errors++;
         $error("FAIL scoreboard_underflow observed=0x%0h expected=none", obs);
         return;
      end
      tag   = tag_q.pop_front();
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   // Negedges spent with signal sel at lvl, starting at the current negedge; capped at bound.
   task automatic count_while(input int sel, input logic lvl, input int bound, output int n);
      n = 0;
      while (sig(sel) === lvl && n < bound) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic lose_and_relock(output int t);
      int n;
      t = 0;
      isLocked = 1'b0;
      count_while(2, 1'b1, 20, n);
      if (n >= 20) t++;
      isLocked = 1'b1;
      count_while(2, 1'b0, 100, n);
      if (n >= 100) t++;
   endtask

   initial begin
      int n;
      int t;
      int tmo;
      resetN    = 1'b0;
      isLocked  = 1'b0;
      relockReq = 1'b0;

      @(negedge clk);
      sb_push("reset_outs", exp_snap(0, 0, 0, 0, 0));
      sb_check(snap());

      // power-up, lock 5 cycles after PLL release
      @(negedge clk);
      resetN = 1'b1;
      sb_push("pwrup_rst_len", RST_CYCLES);
      count_while(0, 1'b0, 50, n);
      sb_check(n);
      repeat (5) @(negedge clk);
      isLocked = 1'b1;
      sb_push("lock_to_core", LOCK_TO_CORE);
      count_while(1, 1'b0, 100, n);
      sb_check(n);
      sb_push("run_outs", exp_snap(1, 1, 1, 0, 0));
      sb_check(snap());

      // lock low for 10 cycles in RUN
      isLocked = 1'b0;
      sb_push("loss_latency", LOSS_LAT);
      count_while(1, 1'b1, 50, n);
      sb_check(n);
      repeat (10 - LOSS_LAT) @(negedge clk);
      sb_push("after_loss", exp_snap(1, 0, 0, 0, 1));
      sb_check(snap());
      isLocked = 1'b1;
      sb_push("relock_latency", LOCK_TO_CORE);
      count_while(1, 1'b0, 100, n);
      sb_check(n);

`ifdef LOCK_GLITCH_FILTER_EN
      isLocked = 1'b0;
      repeat (GLITCH_CYCLES - 1) @(negedge clk);
      isLocked = 1'b1;
      repeat (8) @(negedge clk);
      sb_push("short_glitch_ignored", exp_snap(1, 1, 1, 0, 1));
      sb_check(snap());
`endif

      // relock from RUN, then a one-cycle lock drop in the 6th SETTLE cycle
      relockReq = 1'b1;
      @(negedge clk);
      relockReq = 1'b0;
      sb_push("relock_outs", exp_snap(0, 0, 0, 0, 1));
      sb_check(snap());
      sb_push("relock_rst_len", RST_CYCLES);
      count_while(0, 1'b0, 50, n);
      sb_check(n);
      repeat (4) @(negedge clk);
      isLocked = 1'b0;
      @(negedge clk);
      isLocked = 1'b1;
      sb_push("settle_restart", LOCK_TO_CORE);
      count_while(1, 1'b0, 100, n);
      sb_check(n);

      // relockReq on the same edge as the lock-loss trigger
      isLocked = 1'b0;
      repeat (LOSS_LAT - 1) @(negedge clk);
      relockReq = 1'b1;
      @(negedge clk);
      relockReq = 1'b0;
      sb_push("relock_and_loss", exp_snap(0, 0, 0, 0, 2));
      sb_check(snap());
      sb_push("relock_loss_rst_len", RST_CYCLES);
      count_while(0, 1'b0, 50, n);
      sb_check(n);

      // lock never comes: three waits, two retries, then FAIL
      sb_push("wait1", LOCK_TIMEOUT);
      count_while(0, 1'b1, 100, n);
      sb_check(n);
      sb_push("retry_rst1", RST_CYCLES);
      count_while(0, 1'b0, 50, n);
      sb_check(n);
      sb_push("wait2", LOCK_TIMEOUT);
      count_while(0, 1'b1, 100, n);
      sb_check(n);
      sb_push("retry_rst2", RST_CYCLES);
      count_while(0, 1'b0, 50, n);
      sb_check(n);
      sb_push("wait3", LOCK_TIMEOUT);
      count_while(3, 1'b0, 100, n);
      sb_check(n);
      sb_push("fail_outs", exp_snap(1, 0, 0, 1, 2));
      sb_check(snap());
      repeat (20) @(negedge clk);
      sb_push("fail_sticky", exp_snap(1, 0, 0, 1, 2));
      sb_check(snap());
      relockReq = 1'b1;
      @(negedge clk);
      relockReq = 1'b0;
      sb_push("fail_relock", exp_snap(0, 0, 0, 0, 2));
      sb_check(snap());

      // async reset in SETTLE
      isLocked = 1'b1;
      sb_push("fail_relock_rst_len", RST_CYCLES);
      count_while(0, 1'b0, 50, n);
      sb_check(n);
      repeat (3) @(negedge clk);
      #2 resetN = 1'b0;
      #1;
      sb_push("reset_in_settle", exp_snap(0, 0, 0, 0, 0));
      sb_check(snap());
      @(negedge clk);
      resetN = 1'b1;
      sb_push("settle_reset_rst_len", RST_CYCLES);
      count_while(0, 1'b0, 50, n);
      sb_check(n);
      sb_push("settle_after_reset", 1 + SETTLE_CYCLES);
      count_while(2, 1'b0, 100, n);
      sb_check(n);

      // async reset in RUN
      #2 resetN = 1'b0;
      #1;
      sb_push("reset_in_run", exp_snap(0, 0, 0, 0, 0));
      sb_check(snap());
      @(negedge clk);
      resetN = 1'b1;
      sb_push("run_reset_rst_len", RST_CYCLES);
      count_while(0, 1'b0, 50, n);
      sb_check(n);
      sb_push("run_after_reset", 1 + SETTLE_CYCLES);
      count_while(2, 1'b0, 100, n);
      sb_check(n);

      // loss counter saturation
      tmo = 0;
      for (int i = 0; i < 254; i++) begin
         lose_and_relock(t);
         tmo += t;
      end
      sb_push("sat_loop_timeouts", 0);
      sb_check(tmo);
      sb_push("cnt_254", exp_snap(1, 1, 1, 0, 254));
      sb_check(snap());
      lose_and_relock(t);
      sb_push("cnt_255", exp_snap(1, 1, 1, 0, 255));
      sb_check(snap());
      lose_and_relock(t);
      sb_push("cnt_saturated", exp_snap(1, 1, 1, 0, 255));
      sb_check(snap());

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
